// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port memory
// (1-cycle read latency) among NUM_REQ requesters.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   arb_enable          0 blocks new grants; in-flight ops still complete
//   req_valid/_write    per-requester request strobe and direction (1=write)
//   req_addr/_wdata     packed per-requester address / write data
//   req_ready           one-hot combinational accept
//   rsp_valid/_rdata    one-hot read-response strobe and read data
//   mem_*               registered memory command; mem_read_data returns
//                       one cycle after mem_read_enable
//   busy                any request pending or any op in flight
//
// Optional feature (macro MEM_ARB_PERF_CNT_EN): adds perf_clr input and
// perf_wait_cnt output, 16-bit saturating per-requester wait counters.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             arb_enable,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             mem_read_enable,
  output logic                             mem_write_enable,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_write_data,
  input  logic [DATA_WIDTH-1:0]            mem_read_data,
  output logic                             busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  input  logic                             perf_clr,
  output logic [NUM_REQ*16-1:0]            perf_wait_cnt
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [PTR_W-1:0]      s1_id_q, s1_id_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                  s2_wr_q, s2_wr_d;
  logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_hold_d;

  logic                  gnt_found;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      cand_idx;
  logic [NUM_REQ-1:0]    gnt_oh;

  // Round-robin search starting at ptr; gated off in reset so ready is 0 there.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    gnt_oh    = '0;
    if (rst_n && arb_enable) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand_idx = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
        if (!gnt_found && req_valid[cand_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand_idx;
        end
      end
      gnt_oh[gnt_idx] = gnt_found;
    end
  end

  // Stage 1 = memory command, stage 2 = read response (one-hot id) / write marker.
  always_comb begin
    ptr_d        = ptr_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    s1_id_d      = s1_id_q;
    rsp_valid_d  = '0;
    s2_wr_d      = mem_we_q;
    rdata_hold_d = rdata_hold_q;
    if (gnt_found) begin
      ptr_d       = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      mem_re_d    = !req_write[gnt_idx];
      mem_we_d    = req_write[gnt_idx];
      mem_addr_d  = req_addr[32'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata_d = req_wdata[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
      s1_id_d     = gnt_idx;
    end
    if (mem_re_q) begin
      rsp_valid_d[s1_id_q] = 1'b1;
    end
    // Keep the last returned word so rsp_rdata is stable between responses.
    if (|rsp_valid_q) begin
      rdata_hold_d = mem_read_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      s1_id_q      <= '0;
      rsp_valid_q  <= '0;
      s2_wr_q      <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      s1_id_q      <= s1_id_d;
      rsp_valid_q  <= rsp_valid_d;
      s2_wr_q      <= s2_wr_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign req_ready        = gnt_oh;
  assign rsp_valid        = rsp_valid_q;
  // Memory output is live in the response cycle; pass it straight through.
  assign rsp_rdata        = (|rsp_valid_q) ? mem_read_data : rdata_hold_q;
  assign mem_read_enable  = mem_re_q;
  assign mem_write_enable = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;
  assign busy             = rst_n & ((|req_valid) | mem_re_q | mem_we_q |
                                     (|rsp_valid_q) | s2_wr_q);

`ifdef MEM_ARB_PERF_CNT_EN
  localparam int unsigned CNT_W = 16;

  logic [NUM_REQ*CNT_W-1:0] perf_cnt_q, perf_cnt_d;

  // Saturating per-requester stall counters; clear wins over increment.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (perf_clr) begin
        perf_cnt_d[i*CNT_W +: CNT_W] = '0;
      end else if (req_valid[i] && !req_ready[i] &&
                   (perf_cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        perf_cnt_d[i*CNT_W +: CNT_W] = perf_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_wait_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NUM_REQ=4, 32-bit data, 8-bit address)
// with a behavioural single-port memory attached to the mem_* port.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        arb_enable;
  logic [3:0]  req_valid;
  logic [3:0]  req_write;
  logic [31:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [7:0]  mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;
`ifdef MEM_ARB_PERF_CNT_EN
  logic        perf_clr;
  logic [63:0] perf_wait_cnt;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] mem_model [256];

  mem_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .arb_enable       (arb_enable),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .busy             (busy)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_clr         (perf_clr),
    .perf_wait_cnt    (perf_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_write_enable) mem_model[mem_addr] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= mem_model[mem_addr];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [31:0] d);
    req_write[i]         = wr;
    req_addr[i*8 +: 8]   = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  initial begin
    rst_n      = 1'b0;
    arb_enable = 1'b1;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
`ifdef MEM_ARB_PERF_CNT_EN
    perf_clr   = 1'b0;
`endif

    // Reset values
    #3;
    chk("rst_ready",  req_ready,        4'b0000);
    chk("rst_rspv",   rsp_valid,        4'b0000);
    chk("rst_rdata",  rsp_rdata,        32'h0);
    chk("rst_re",     mem_read_enable,  1'b0);
    chk("rst_we",     mem_write_enable, 1'b0);
    chk("rst_addr",   mem_addr,         8'h00);
    chk("rst_wdata",  mem_write_data,   32'h0);
    chk("rst_busy",   busy,             1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write 0xDEADBEEF @0x10 from req0, then req1 reads it back
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
    req_valid = 4'b0001;
    #1;
    chk("wr_ready", req_ready, 4'b0001);
    tick();
    set_req(1, 1'b0, 8'h10, 32'h0);
    req_valid = 4'b0010;
    #1;
    chk("wr_we",    mem_write_enable, 1'b1);
    chk("wr_re",    mem_read_enable,  1'b0);
    chk("wr_addr",  mem_addr,         8'h10);
    chk("wr_data",  mem_write_data,   32'hDEADBEEF);
    chk("rd_ready", req_ready,        4'b0010);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("rd_re",    mem_read_enable,  1'b1);
    chk("rd_we",    mem_write_enable, 1'b0);
    chk("rd_addr",  mem_addr,         8'h10);
    chk("wr_norsp", rsp_valid,        4'b0000);
    tick();
    chk("rd_rspv",  rsp_valid,        4'b0010);
    chk("rd_rdata", rsp_rdata,        32'hDEADBEEF);
    tick();
    chk("rd_rspv0", rsp_valid,        4'b0000);
    chk("rd_hold",  rsp_rdata,        32'hDEADBEEF);
    chk("idle_re",  mem_read_enable,  1'b0);
    chk("idle_busy", busy,            1'b0);

    // Preload 0x20..0x23 with 0xCAFE0020+i through req0
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 8'(32'h20 + i), 32'hCAFE0020 + 32'(i));
      req_valid = 4'b0001;
      #1;
      chk("pre_ready", req_ready, 4'b0001);
      tick();
    end
    req_valid = 4'b0000;
    tick();
    tick();

    // Fairness from reset: all four read continuously
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(32'h20 + i), 32'h0);
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      chk("rr_ready", req_ready, ((k < 8) ? (4'b0001 << (k % 4)) : 4'b0000));
      if (k >= 1 && k <= 8) begin
        chk("rr_re",   mem_read_enable, 1'b1);
        chk("rr_addr", mem_addr, 8'(32'h20 + (k - 1) % 4));
      end
      if (k >= 2) begin
        chk("rr_rspv",  rsp_valid, (4'b0001 << ((k - 2) % 4)));
        chk("rr_rdata", rsp_rdata, 32'hCAFE0020 + 32'((k - 2) % 4));
      end
      tick();
    end

    // Wrap/skip: move ptr to 3, then only req0/req2 compete
    set_req(2, 1'b0, 8'h22, 32'h0);
    req_valid = 4'b0100;
    #1;
    chk("ws_pre", req_ready, 4'b0100);
    tick();
    set_req(0, 1'b0, 8'h20, 32'h0);
    req_valid = 4'b0101;
    #1;
    chk("ws_g0", req_ready, 4'b0001);
    tick();
    #1;
    chk("ws_g1",    req_ready, 4'b0100);
    chk("ws_rspv1", rsp_valid, 4'b0100);
    chk("ws_rd1",   rsp_rdata, 32'hCAFE0022);
    tick();
    #1;
    chk("ws_g2",    req_ready, 4'b0001);
    chk("ws_rspv2", rsp_valid, 4'b0001);
    chk("ws_rd2",   rsp_rdata, 32'hCAFE0020);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("ws_rspv3", rsp_valid, 4'b0100);
    chk("ws_rd3",   rsp_rdata, 32'hCAFE0022);
    tick();
    chk("ws_rspv4", rsp_valid, 4'b0001);
    chk("ws_rd4",   rsp_rdata, 32'hCAFE0020);
    tick();

    // arb_enable=0 with a req2 read in flight (ptr=1 here)
    set_req(2, 1'b0, 8'h23, 32'h0);
    req_valid = 4'b0100;
    #1;
    chk("en_g0", req_ready, 4'b0100);
    tick();
    arb_enable = 1'b0;
    #1;
    chk("en_ready1", req_ready,       4'b0000);
    chk("en_re",     mem_read_enable, 1'b1);
    chk("en_addr",   mem_addr,        8'h23);
    chk("en_busy1",  busy,            1'b1);
    tick();
    chk("en_ready2", req_ready, 4'b0000);
    chk("en_rspv",   rsp_valid, 4'b0100);
    chk("en_rdata",  rsp_rdata, 32'hCAFE0023);
    chk("en_busy2",  busy,      1'b1);
    tick();
    chk("en_rspv0",  rsp_valid, 4'b0000);
    chk("en_busy3",  busy,      1'b1);
    req_valid = 4'b0000;
    #1;
    chk("en_busy4",  busy,      1'b0);
    // Re-enable: ptr is 3, so req1 wins over req2
    arb_enable = 1'b1;
    set_req(1, 1'b0, 8'h21, 32'h0);
    req_valid = 4'b0110;
    #1;
    chk("en_resume", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("mr_re",   mem_read_enable, 1'b1);
    chk("mr_addr", mem_addr,        8'h21);

    // Reset one cycle after accepting a read
    rst_n = 1'b0;
    #1;
    chk("mr_re0",    mem_read_enable,  1'b0);
    chk("mr_we0",    mem_write_enable, 1'b0);
    chk("mr_addr0",  mem_addr,         8'h00);
    chk("mr_wdata0", mem_write_data,   32'h0);
    chk("mr_rspv0",  rsp_valid,        4'b0000);
    chk("mr_rdata0", rsp_rdata,        32'h0);
    chk("mr_busy0",  busy,             1'b0);
    req_valid = 4'b0001;
    #1;
    chk("mr_ready0", req_ready, 4'b0000);
    req_valid = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mr_norsp", rsp_valid, 4'b0000);
      tick();
    end

    // Disabled for 2 cycles with all four waiting, then grants 0..3 from ptr=0
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(32'h20 + i), 32'h0);
    arb_enable = 1'b0;
    req_valid  = 4'hF;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("dis_ready", req_ready, 4'b0000);
      tick();
    end
    arb_enable = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("post_rst_g", req_ready, (4'b0001 << g));
      tick();
      req_valid[g] = 1'b0;
    end
`ifdef MEM_ARB_PERF_CNT_EN
    #1;
    chk("perf3", perf_wait_cnt[48 +: 16], 16'd5);
    chk("perf0", perf_wait_cnt[0 +: 16],  16'd2);
    chk("perf2", perf_wait_cnt[32 +: 16], 16'd4);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    #1;
    chk("perf_clr3", perf_wait_cnt[48 +: 16], 16'd0);
    chk("perf_clr2", perf_wait_cnt[32 +: 16], 16'd0);
    arb_enable = 1'b0;
    req_valid  = 4'b1000;
    repeat (70000) tick();
    chk("perf_sat3", perf_wait_cnt[48 +: 16], 16'hFFFF);
    chk("perf_sat0", perf_wait_cnt[0 +: 16],  16'd0);
    req_valid  = 4'b0000;
    arb_enable = 1'b1;
`endif
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
